bitsum_seq: RTL and testbench

// - Sequential byte-sum engine: on start, captures a 32-bit word and adds its four unsigned

---
 rtl/bitsum_pkg.sv | 19 +
 rtl/bitsum_byte_acc.sv | 22 ++
 rtl/bitsum.sv | 85 ++++++++
 tb/tb_bitsum_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bitsum_pkg.sv
// Shared types and sizing constants for the sequential byte-sum engine.
package bitsum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NBYTES = DATA_W / BYTE_W;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/bitsum_byte_acc.sv
// Combinational byte select, zero-extend and add onto the running accumulator.
module bitsum_byte_acc
  import bitsum_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [DATA_W-1:0] operand_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [OUT_W-1:0]  acc_i,
  output logic [OUT_W-1:0]  sum_o
);

  logic [BYTE_W-1:0] byte_sel;

  always_comb begin
    byte_sel = operand_i[idx_i*BYTE_W +: BYTE_W];
    sum_o    = acc_i + OUT_W'(byte_sel);
  end

endmodule

// File: rtl/bitsum.sv
// bitsum_seq: captures an operand on start and sums its bytes, LSB byte first,
// one byte per clock; finish is sticky until the next accepted start.
module bitsum_seq
  import bitsum_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  output logic              finish,
  output logic [OUT_W-1:0]  bitsum
);

  localparam int unsigned NB   = DATA_W / BYTE_W;
  localparam int unsigned IDXW = idx_width(NB);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              fin_q, fin_d;
  logic [OUT_W-1:0]  acc_next;

  bitsum_byte_acc #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .IDX_W  (IDXW)
  ) u_acc (
    .operand_i (op_q),
    .idx_i     (idx_q),
    .acc_i     (acc_q),
    .sum_o     (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    fin_d   = fin_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d    = in;
          acc_d   = '0;
          idx_d   = '0;
          fin_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDXW'(NB - 1)) begin
          fin_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign finish = fin_q;
  assign bitsum = acc_q;

endmodule

// File: tb/tb_bitsum_seq.sv
// Randomized and directed self-checking bench for bitsum_seq.
module tb_bitsum_seq;

  localparam int unsigned NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic        finish;
  logic [31:0] bitsum;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bitsum_seq #(
    .DATA_W (32),
    .OUT_W  (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in),
    .finish (finish),
    .bitsum (bitsum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: sum of the lowest k bytes of v as plain integers.
  function automatic logic [31:0] partial_sum(input logic [31:0] v, input int unsigned k);
    int unsigned s = 0;
    for (int unsigned b = 0; b < k; b++) s += (v >> (8 * b)) & 32'hFF;
    return 32'(s);
  endfunction

  // Issues one start from IDLE/DONE and checks every cycle until finish.
  task automatic run_op(input logic [31:0] v, input logic [31:0] exp_final, input bit noise);
    in    = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("accept_finish", 32'(finish), 32'd0);
    check_val("accept_sum", bitsum, 32'd0);
    for (int unsigned k = 1; k <= NB; k++) begin
      if (noise) begin
        in    = $urandom;
        start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_val("busy_sum", bitsum, partial_sum(v, k));
      check_val("busy_finish", 32'(finish), (k == NB) ? 32'd1 : 32'd0);
    end
    check_val("final_sum", bitsum, exp_final);
  endtask

  logic [31:0] dir_in  [8] = '{32'h80000000, 32'h80000800, 32'h84080804, 32'h9010C83C,
                               32'hF8524A22, 32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF};
  logic [31:0] dir_exp [8] = '{32'h080, 32'h088, 32'h098, 32'h1A4,
                               32'h1B6, 32'h1FE, 32'h1FE, 32'h3FC};

  initial begin
    logic [31:0] v;
    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
    #1;
    check_val("rst_finish", 32'(finish), 32'd0);
    check_val("rst_sum", bitsum, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check_val("rst_hold_finish", 32'(finish), 32'd0);
      check_val("rst_hold_sum", bitsum, 32'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("idle_finish", 32'(finish), 32'd0);
      check_val("idle_sum", bitsum, 32'd0);
    end

    // Zero operand with start held for two cycles: second cycle lands in BUSY.
    in    = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    check_val("zero_accept_finish", 32'(finish), 32'd0);
    for (int unsigned k = 1; k <= NB; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_val("zero_finish", 32'(finish), (k == NB) ? 32'd1 : 32'd0);
      check_val("zero_sum", bitsum, 32'd0);
    end
    repeat (2) begin
      @(posedge clk); #1;
      check_val("done_hold_finish", 32'(finish), 32'd1);
    end

    for (int unsigned i = 0; i < 8; i++) run_op(dir_in[i], dir_exp[i], 1'b0);

    // Hold in DONE, then back-to-back restart with noise during BUSY.
    repeat (2) @(posedge clk);
    #1;
    check_val("done_hold_sum", bitsum, 32'h3FC);
    for (int unsigned i = 0; i < 24; i++) begin
      v = $urandom;
      run_op(v, partial_sum(v, NB), 1'b1);
    end

    // Start held high through DONE re-accepts and restarts.
    v     = 32'h01020304;
    in    = v;
    start = 1'b1;
    repeat (NB + 1) @(posedge clk);
    #1;
    check_val("held_finish", 32'(finish), 32'd1);
    check_val("held_sum", bitsum, 32'h0A);
    in = 32'h10101010;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("reaccept_finish", 32'(finish), 32'd0);
    check_val("reaccept_sum", bitsum, 32'd0);
    repeat (NB) @(posedge clk);
    #1;
    check_val("reaccept_final", bitsum, 32'h40);
    check_val("reaccept_fin", 32'(finish), 32'd1);

    // Async reset mid-BUSY.
    in    = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("pre_abort_sum", bitsum, 32'h1FE);
    #2 rst = 1'b1;
    #1;
    check_val("abort_finish", 32'(finish), 32'd0);
    check_val("abort_sum", bitsum, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'h9010C83C, 32'h1A4, 1'b0);

    // Async reset while DONE clears the sticky finish.
    #2 rst = 1'b1;
    #1;
    check_val("done_rst_finish", 32'(finish), 32'd0);
    check_val("done_rst_sum", bitsum, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'hF8524A22, 32'h1B6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
